ts_null_stuffer: RTL and testbench
==================================

Name: ts_null_stuffer

Overview:
- Sits directly downstream of the T2-MI-over-TS packer.
- Takes its bursty 188-byte TS packet stream (byte strobe plus sync flag) and buffers whole packets in an internal packet RAM.
- Replays them at a constant byte rate set by an external TICK strobe.
- Whenever no complete packet is buffered at a packet boundary, it inserts a null packet (PID 0x1FFF), so the output TS is gap-free for the modulator/ASI interface.

Parameters:
- SLOTS_LOG2, 2, log2 of packet slots in the buffer (default 4 slots = 752 bytes).
- NULL_FILL, 8'hFF, payload byte value used in null packets.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- DATA_IN  in  8  TS byte from packer.
- ENA_IN  in  1  DATA_IN valid strobe, one byte per high cycle.
- PSYNC_IN  in  1  high with byte 0 (0x47) of each packet.
- TICK  in  1  output byte-rate enable; may be high any cycle, including every cycle.
- DATA_OUT  out  8  output TS byte.
- ENA_OUT  out  1  DATA_OUT valid, one pulse per TICK.
- PSYNC_OUT  out  1  high with output byte 0.
- PKT_CNT  out  SLOTS_LOG2+1  committed packets currently buffered.
- OVF  out  1  sticky: a packet was dropped because the buffer was full.
- SYNC_ERR  out  1  one-cycle pulse: packet aborted by an early PSYNC_IN.

Behaviour:
- Reset (async, RST low):
  - All outputs 0.
  - Write/read slot pointers, byte indices and count 0.
  - Write FSM in W_HUNT, read FSM in R_BOUND.
  - Reset mid-packet discards any partial packet; RAM contents are don't-care.
- RAM:
  - 2^SLOTS_LOG2*188 bytes; address = slot*188 + index.
  - Synchronous write, registered read.
- Write FSM (states W_HUNT, W_PKT, W_DROP); all transitions on ENA_IN=1 only:
  - W_HUNT: accept a byte only if PSYNC_IN=1 and DATA_IN=0x47.
    - If count < 2^SLOTS_LOG2: write index 0, go W_PKT with index=1.
    - Otherwise: set OVF, go W_DROP with index=1.
    - Bytes not matching the sync condition are ignored.
  - W_PKT: write the byte at the current index, then index+1.
    - After index 187 is written: commit the slot (wr_slot+1 mod slots, count+1), go W_HUNT.
  - W_DROP: consume bytes without writing; after byte 187, go W_HUNT.
  - PSYNC_IN=1 at index 1..187 in W_PKT or W_DROP:
    - Pulse SYNC_ERR; the partial packet is not committed.
    - The byte is handled exactly as in W_HUNT (new packet start if 0x47).
- Read FSM (states R_BOUND, R_DATA, R_NULL); advances only on TICK=1:
  - R_BOUND, on TICK:
    - If count > 0: read byte 0 of rd_slot, go R_DATA with rindex=1.
    - Else: emit null byte 0, go R_NULL with rindex=1.
    - The source decision is made only here. A packet committed during a null packet waits for the next boundary.
  - R_DATA: each TICK reads rd_slot at rindex, then rindex+1.
    - On rindex=187: release the slot (rd_slot+1, count-1), go R_BOUND.
  - R_NULL: bytes 0..3 = 47 1F FF 10 (PUSI=0, PID 0x1FFF, AFC=01, CC=0); bytes 4..187 = NULL_FILL.
    - After byte 187, go R_BOUND.
- Output timing:
  - Fixed latency of 2 CLK cycles from TICK sampled high to ENA_OUT high with the corresponding byte.
  - Null bytes pass through the same 2-stage delay as RAM bytes, so both sources are aligned.
  - PSYNC_OUT is high only on the byte-0 ENA_OUT cycle.
  - DATA_OUT holds its value when ENA_OUT=0.
- Count arithmetic:
  - Commit and release in the same cycle leave count unchanged.
  - count never exceeds 2^SLOTS_LOG2 (overflow handled by drop) and never underflows (release only from R_DATA).
- Pointers wrap modulo 2^SLOTS_LOG2.
- Read and write of the same slot cannot coincide, because a slot is read only after it is committed.

Test Plan:
- Reset with RST=0 mid-stream -> all outputs 0, PKT_CNT=0. After release with TICK every 3rd cycle and no input -> continuous null packets 47 1F FF 10 FF.., PSYNC_OUT every 188 ENA_OUT pulses, ENA_OUT exactly 2 cycles after each TICK.
- One packet (47 40 10 10, then 00..B7), ENA_IN with random gaps, TICK every cycle -> PKT_CNT goes 1. At the next boundary the packet is output byte-exact, then nulls resume and PKT_CNT returns to 0.
- TICK=0, write 5 packets with payload first bytes 01..05 -> PKT_CNT=4, OVF=1, 5th dropped. Then TICK on -> packets 01,02,03,04 in order, then nulls.
- PSYNC_IN with 0x47 at index 100 of a packet -> SYNC_ERR one-cycle pulse, partial packet discarded. The new packet is captured and output intact; PKT_CNT increments by 1 only.
- PKT_CNT=1 and a read packet ending on the same cycle a write packet commits -> PKT_CNT stays 1, the next boundary outputs the new packet.
- A packet committed during null-packet byte 50 -> null packet completes all 188 bytes before the buffered packet starts.

Source files
------------

// File: rtl/ts_null_stuffer.sv
// Buffers whole 188-byte TS packets from the packer and replays them at the TICK byte rate,
// inserting null packets (PID 0x1FFF) whenever no complete packet is ready at a boundary.
module ts_null_stuffer #(
    parameter int unsigned SLOTS_LOG2 = 2,
    parameter logic [7:0]  NULL_FILL  = 8'hFF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          DATA_IN,
    input  logic                ENA_IN,
    input  logic                PSYNC_IN,
    input  logic                TICK,
    output logic [7:0]          DATA_OUT,
    output logic                ENA_OUT,
    output logic                PSYNC_OUT,
    output logic [SLOTS_LOG2:0] PKT_CNT,
    output logic                OVF,
    output logic                SYNC_ERR
);
    localparam int unsigned SLOTS = 1 << SLOTS_LOG2;
    localparam int unsigned DEPTH = SLOTS * 188;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = SLOTS_LOG2 + 1;
    localparam logic [7:0]  LAST_IDX  = 8'd187;
    localparam logic [7:0]  SYNC_BYTE = 8'h47;
    localparam logic [CW-1:0] FULL    = CW'(SLOTS);

    typedef enum logic [1:0] {W_HUNT, W_PKT, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_BOUND, R_DATA, R_NULL} rstate_t;

    wstate_t               w_state, w_state_nx;
    rstate_t               r_state, r_state_nx;
    logic [7:0]            w_idx, w_idx_nx, wr_idx;
    logic [7:0]            r_idx, r_idx_nx;
    logic [SLOTS_LOG2-1:0] wr_slot, rd_slot;
    logic [CW-1:0]         cnt;
    logic                  wr_en, commit, sync_err_nx, ovf_set;
    logic                  rd_en, rel_slot, s1_null_nx;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [7:0]            mem [DEPTH];
    logic [7:0]            ram_q;
    logic                  s1_vld, s1_sync, s1_null;
    logic [7:0]            s1_byte;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    return 8'h47;
            8'd1:    return 8'h1F;
            8'd2:    return 8'hFF;
            8'd3:    return 8'h10;
            default: return NULL_FILL;
        endcase
    endfunction

    // Write side: an early PSYNC_IN inside a packet is re-evaluated as a fresh hunt on the same byte.
    always_comb begin
        w_state_nx  = w_state;
        w_idx_nx    = w_idx;
        wr_idx      = w_idx;
        wr_en       = 1'b0;
        commit      = 1'b0;
        sync_err_nx = 1'b0;
        ovf_set     = 1'b0;
        if (ENA_IN) begin
            if (w_state == W_HUNT || PSYNC_IN) begin
                sync_err_nx = (w_state != W_HUNT);
                w_state_nx  = W_HUNT;
                w_idx_nx    = '0;
                if (PSYNC_IN && DATA_IN == SYNC_BYTE) begin
                    w_idx_nx = 8'd1;
                    wr_idx   = '0;
                    if (cnt < FULL) begin
                        wr_en      = 1'b1;
                        w_state_nx = W_PKT;
                    end else begin
                        ovf_set    = 1'b1;
                        w_state_nx = W_DROP;
                    end
                end
            end else begin
                wr_en = (w_state == W_PKT);
                if (w_idx == LAST_IDX) begin
                    commit     = (w_state == W_PKT);
                    w_state_nx = W_HUNT;
                    w_idx_nx   = '0;
                end else begin
                    w_idx_nx = w_idx + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            w_state  <= W_HUNT;
            w_idx    <= '0;
            wr_slot  <= '0;
            OVF      <= 1'b0;
            SYNC_ERR <= 1'b0;
        end else begin
            w_state  <= w_state_nx;
            w_idx    <= w_idx_nx;
            SYNC_ERR <= sync_err_nx;
            if (ovf_set) OVF <= 1'b1;
            if (commit)  wr_slot <= wr_slot + SLOTS_LOG2'(1);
        end
    end

    // Read side: the data/null decision is taken only at a packet boundary.
    always_comb begin
        r_state_nx = r_state;
        r_idx_nx   = r_idx;
        rd_en      = 1'b0;
        rel_slot   = 1'b0;
        s1_null_nx = 1'b0;
        if (TICK) begin
            r_idx_nx = r_idx + 8'd1;
            unique case (r_state)
                R_BOUND: begin
                    if (cnt != '0) begin
                        rd_en      = 1'b1;
                        r_state_nx = R_DATA;
                    end else begin
                        s1_null_nx = 1'b1;
                        r_state_nx = R_NULL;
                    end
                end
                R_DATA: begin
                    rd_en = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        rel_slot   = 1'b1;
                        r_state_nx = R_BOUND;
                        r_idx_nx   = '0;
                    end
                end
                R_NULL: begin
                    s1_null_nx = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state_nx = R_BOUND;
                        r_idx_nx   = '0;
                    end
                end
                default: begin
                    r_state_nx = R_BOUND;
                    r_idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= R_BOUND;
            r_idx   <= '0;
            rd_slot <= '0;
            cnt     <= '0;
        end else begin
            r_state <= r_state_nx;
            r_idx   <= r_idx_nx;
            if (rel_slot) rd_slot <= rd_slot + SLOTS_LOG2'(1);
            case ({commit, rel_slot})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign wr_addr = AW'(wr_slot) * AW'(188) + AW'(wr_idx);
    assign rd_addr = AW'(rd_slot) * AW'(188) + AW'(r_idx);

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= DATA_IN;
        if (rd_en) ram_q <= mem[rd_addr];
    end

    // Null bytes ride a stage-1 register so they line up with the registered RAM read.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_vld    <= 1'b0;
            s1_sync   <= 1'b0;
            s1_null   <= 1'b0;
            s1_byte   <= '0;
            ENA_OUT   <= 1'b0;
            PSYNC_OUT <= 1'b0;
            DATA_OUT  <= '0;
        end else begin
            s1_vld    <= TICK;
            s1_sync   <= TICK && (r_state == R_BOUND);
            s1_null   <= s1_null_nx;
            s1_byte   <= null_byte(r_idx);
            ENA_OUT   <= s1_vld;
            PSYNC_OUT <= s1_sync;
            if (s1_vld) DATA_OUT <= s1_null ? s1_byte : ram_q;
        end
    end

    assign PKT_CNT = cnt;

endmodule

// File: tb/tb_ts_null_stuffer.sv
// Self-checking bench for ts_null_stuffer: packet-queue reference model, scenario table, corner sequences.
module tb_ts_null_stuffer;
    localparam int unsigned SL    = 2;
    localparam int unsigned SLOTS = 4;
    localparam logic [7:0]  NF    = 8'hFF;
    localparam logic [23:0] NULL_REC = {8'h1F, 8'hFF, NF};

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  DATA_IN = '0;
    logic        ENA_IN = 1'b0, PSYNC_IN = 1'b0, TICK = 1'b0;
    logic [7:0]  DATA_OUT;
    logic        ENA_OUT, PSYNC_OUT, OVF, SYNC_ERR;
    logic [SL:0] PKT_CNT;

    int checks = 0;
    int errors = 0;

    ts_null_stuffer #(.SLOTS_LOG2(SL), .NULL_FILL(NF)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
        .TICK(TICK), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC_OUT(PSYNC_OUT),
        .PKT_CNT(PKT_CNT), .OVF(OVF), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed packets live as whole byte runs in a queue; outputs appear two cycles after a TICK.
    typedef struct packed {logic vld; logic sync; logic [7:0] b;} ent_t;
    ent_t       d1, d2;
    logic [7:0] bq[$];
    logic [7:0] wbuf[188];
    int         m_cnt, w_pos, r_pos;
    bit         w_keep, r_data, m_ovf, m_serr;
    logic [7:0] m_dout;

    function automatic logic [7:0] nb(input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return NF;
        endcase
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        int   old_cnt;
        ent_t e;
        if (!RST) begin
            d1 = '0; d2 = '0; bq.delete();
            m_cnt = 0; w_pos = 0; r_pos = 0; w_keep = 0; r_data = 0;
            m_ovf = 0; m_serr = 0; m_dout = '0;
        end else begin
            old_cnt = m_cnt;
            e = '0;
            if (TICK) begin
                if (r_pos == 0) r_data = (old_cnt > 0);
                e.vld  = 1'b1;
                e.sync = (r_pos == 0);
                e.b    = r_data ? bq.pop_front() : nb(r_pos);
                r_pos++;
                if (r_pos == 188) begin
                    r_pos = 0;
                    if (r_data) m_cnt--;
                end
            end
            m_serr = 0;
            if (ENA_IN) begin
                if (w_pos == 0 || PSYNC_IN) begin
                    if (w_pos != 0) m_serr = 1;
                    w_pos = 0;
                    if (PSYNC_IN && DATA_IN == 8'h47) begin
                        w_keep = (old_cnt < SLOTS);
                        if (!w_keep) m_ovf = 1;
                        wbuf[0] = DATA_IN;
                        w_pos = 1;
                    end
                end else begin
                    wbuf[w_pos] = DATA_IN;
                    w_pos++;
                    if (w_pos == 188) begin
                        w_pos = 0;
                        if (w_keep) begin
                            for (int i = 0; i < 188; i++) bq.push_back(wbuf[i]);
                            m_cnt++;
                        end
                    end
                end
            end
            d2 = d1;
            d1 = e;
            if (d2.vld) m_dout = d2.b;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            check("ena_out",   ENA_OUT,   d2.vld);
            check("psync_out", PSYNC_OUT, d2.vld & d2.sync);
            check("data_out",  DATA_OUT,  m_dout);
            check("pkt_cnt",   PKT_CNT,   m_cnt);
            check("ovf",       OVF,       m_ovf);
            check("sync_err",  SYNC_ERR,  m_serr);
        end
    end

    // Output monitor: records {byte1, byte2, byte4} of each complete output packet.
    logic [7:0]  cur[188];
    logic [23:0] outq[$];
    int          mpos, since, serr_cnt;
    bit          seen_ps;

    always @(negedge CLK) begin
        if (!RST) begin
            mpos = 0; since = 0; seen_ps = 0;
        end else begin
            if (SYNC_ERR) serr_cnt++;
            if (ENA_OUT) begin
                if (PSYNC_OUT) begin
                    if (seen_ps) check("psync_spacing", since, 188);
                    seen_ps = 1; since = 0; mpos = 0;
                end
                if (seen_ps && mpos < 188) begin
                    cur[mpos] = DATA_OUT;
                    if (mpos == 187) outq.push_back({cur[1], cur[2], cur[4]});
                    mpos++;
                end
                since++;
            end
        end
    end

    function automatic logic [23:0] rec(input int k);
        if (k < outq.size()) return outq[k];
        return '0;
    endfunction

    // Drivers: tmode 0 = TICK off, 1 = every cycle, 3 = every 3rd cycle, other = random.
    int tmode = 0, tph = 0, gap_pct = 0;

    task automatic step();
        @(posedge CLK);
        #1;
        ENA_IN = 1'b0;
        PSYNC_IN = 1'b0;
        tph++;
        case (tmode)
            0:       TICK = 1'b0;
            1:       TICK = 1'b1;
            3:       TICK = (tph % 3 == 0);
            default: TICK = ($urandom_range(0, 99) < 45);
        endcase
    endtask

    task automatic put_byte(input logic [7:0] b, input logic s);
        step();
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step();
        ENA_IN = 1'b1;
        DATA_IN = b;
        PSYNC_IN = s;
    endtask

    function automatic logic [7:0] pkt_byte(input logic [7:0] first, input int i);
        case (i)
            0:       return 8'h47;
            1:       return 8'h40;
            2:       return 8'h10;
            3:       return 8'h10;
            default: return first + 8'(i - 4);
        endcase
    endfunction

    task automatic send_pkt(input logic [7:0] first, input int upto);
        for (int i = 0; i < upto; i++) put_byte(pkt_byte(first, i), i == 0);
    endtask

    task automatic do_reset();
        step();
        RST = 1'b0;
        tmode = 0;
        TICK = 1'b0;
        #2;
        check("rst_data_out",  DATA_OUT,  0);
        check("rst_ena_out",   ENA_OUT,   0);
        check("rst_psync_out", PSYNC_OUT, 0);
        check("rst_pkt_cnt",   PKT_CNT,   0);
        check("rst_ovf",       OVF,       0);
        check("rst_sync_err",  SYNC_ERR,  0);
        step();
        step();
        RST = 1'b1;
        outq.delete();
        serr_cnt = 0;
    endtask

    typedef struct {
        int         n_pkts;
        logic [7:0] first;
        int         abort_at;
        int         exp_cnt;
        logic       exp_ovf;
        int         exp_serr;
        logic [7:0] exp_first;
    } row_t;
    row_t rows[4];

    initial begin : watchdog
        #900us;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first_data;
        rows[0] = '{1, 8'h00, 0,   1, 1'b0, 0, 8'h00};
        rows[1] = '{5, 8'h01, 0,   4, 1'b1, 0, 8'h01};
        rows[2] = '{2, 8'h30, 100, 1, 1'b0, 1, 8'h31};
        rows[3] = '{3, 8'h20, 0,   3, 1'b0, 0, 8'h20};

        do_reset();

        // Randomised traffic: bursty writes, random TICK, aborts and junk bytes.
        for (int p = 0; p < 40; p++) begin
            tmode = 9;
            gap_pct = $urandom_range(0, 70);
            if ($urandom_range(0, 4) == 0) begin
                put_byte(8'($urandom_range(0, 255)), 1'b0);
                put_byte(8'h12, 1'b1);
            end
            if ($urandom_range(0, 5) == 0)
                send_pkt(8'($urandom_range(0, 255)), $urandom_range(1, 187));
            else
                send_pkt(8'($urandom_range(0, 255)), 188);
        end
        repeat (1000) step();

        // Reset in the middle of an incoming packet while output is active.
        tmode = 1;
        gap_pct = 0;
        send_pkt(8'h77, 90);
        do_reset();

        // Idle input: continuous null packets at one byte every 3rd cycle.
        tmode = 3;
        repeat (1300) step();
        check("null_pkt_count", outq.size() >= 2, 1);
        for (int k = 0; k < outq.size(); k++) check("null_pkt_hdr", outq[k], NULL_REC);

        // Scenario table: fill with TICK off, then drain.
        foreach (rows[r]) begin
            do_reset();
            gap_pct = 20;
            for (int p = 0; p < rows[r].n_pkts; p++) begin
                if (p == 0 && rows[r].abort_at != 0) send_pkt(rows[r].first, rows[r].abort_at);
                else send_pkt(rows[r].first + 8'(p), 188);
            end
            step();
            step();
            check("row_pkt_cnt", PKT_CNT, rows[r].exp_cnt);
            check("row_ovf", OVF, rows[r].exp_ovf);
            check("row_sync_err_cnt", serr_cnt, rows[r].exp_serr);
            tmode = 1;
            repeat (188 * (rows[r].exp_cnt + 1) + 10) step();
            check("row_drained_cnt", PKT_CNT, 0);
            for (int k = 0; k < rows[r].exp_cnt; k++)
                check("row_out_pkt", rec(k), {8'h40, 8'h10, rows[r].exp_first + 8'(k)});
            check("row_null_after", rec(rows[r].exp_cnt), NULL_REC);
        end

        // One packet with random input gaps while TICK runs every cycle.
        do_reset();
        tmode = 1;
        gap_pct = 40;
        send_pkt(8'h00, 188);
        step();
        check("single_commit_cnt", PKT_CNT, 1);
        gap_pct = 0;
        repeat (188 * 3) step();
        check("single_drained_cnt", PKT_CNT, 0);
        first_data = -1;
        for (int k = 0; k < outq.size(); k++)
            if (first_data < 0 && outq[k] != NULL_REC) first_data = k;
        check("single_found", first_data >= 0, 1);
        if (first_data >= 0) begin
            check("single_pkt", rec(first_data), 24'h401000);
            check("single_null_after", rec(first_data + 1), NULL_REC);
        end

        // Read of the last byte and a write commit on the same edge.
        do_reset();
        gap_pct = 0;
        send_pkt(8'hA0, 188);
        send_pkt(8'hB0, 187);
        tmode = 1;
        for (int k = 1; k <= 188; k++) begin
            step();
            if (k == 188) begin
                ENA_IN = 1'b1;
                DATA_IN = pkt_byte(8'hB0, 187);
            end
        end
        step();
        check("coincide_cnt", PKT_CNT, 1);
        repeat (200) step();
        check("coincide_first", rec(0), 24'h4010A0);
        check("coincide_second", rec(1), 24'h4010B0);
        check("coincide_drained", PKT_CNT, 0);

        // Commit while null byte 50 is being issued: that null packet completes first.
        do_reset();
        send_pkt(8'h5A, 187);
        tmode = 1;
        for (int k = 1; k <= 51; k++) begin
            step();
            if (k == 51) begin
                ENA_IN = 1'b1;
                DATA_IN = pkt_byte(8'h5A, 187);
            end
        end
        step();
        check("midnull_cnt", PKT_CNT, 1);
        repeat (400) step();
        check("midnull_first_null", rec(0), NULL_REC);
        check("midnull_then_data", rec(1), 24'h40105A);

        tmode = 0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
